// File: rtl/uart_tx_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder_if
// Purpose  : Bundles the producer-side push port, the occupancy/status flags
//            and the transmitter launch handshake of uart_tx_feeder.
// Ports    : (interface signals)
//   wr_en, wr_data         push strobe and byte     (master -> slave)
//   full, empty, count     FIFO occupancy status    (slave  -> master)
//   overflow               dropped-push pulse       (slave  -> master)
//   busy                   byte in flight           (slave  -> master)
//   tx_start, tx_data      launch pulse and byte    (slave  -> master)
//   tx_done                transmitter completion   (master -> slave)
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_feeder_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     count;
  logic                 overflow;
  logic                 busy;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_done;

  // master: producer plus transmitter environment; slave: the feeder itself
  modport master (
    output wr_en, wr_data, tx_done,
    input  full, empty, count, overflow, busy, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_done,
    output full, empty, count, overflow, busy, tx_start, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Byte FIFO plus launch controller in front of a UART transmitter.
//            Bytes pushed with wr_en are queued; one at a time is popped onto
//            tx_data with a one-cycle tx_start pulse, and the next launch
//            waits for the transmitter's tx_done.
// Ports    :
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - uart_tx_feeder_if.slave (push port, status, launch handshake)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  wire              clk,
  input  wire              rst,
  uart_tx_feeder_if.slave  bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int c_PTR_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LAUNCH = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;
  logic                 r_tx_start;
  logic [DATA_BITS-1:0] r_tx_data;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  // Flags come only from the registered count, so pointer equality is never
  // ambiguous when the pointers wrap.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.wr_en & ~w_full;

  // Next-state logic; the pop is tied to the IDLE->LAUNCH transition.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Honoured even in the first LAUNCH cycle (same cycle as tx_start).
        if (bus.tx_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      // A push while full is dropped even if a pop happens on the same edge.
      r_overflow <= bus.wr_en & w_full;
      // tx_start is the registered pop, so it is high only in the first
      // LAUNCH cycle and has no combinational path from any input.
      r_tx_start <= w_pop;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end

      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + c_PTR_W'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
  assign bus.busy     = (r_state == S_LAUNCH);
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Directed self-checking bench for uart_tx_feeder: single byte,
//            fill/overflow, ordering with pointer wrap, simultaneous push and
//            pop, stray/early tx_done, and asynchronous reset mid-frame.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  uart_tx_feeder_if #(.DATA_BITS(8), .DEPTH(16)) u_if ();

  uart_tx_feeder #(.DATA_BITS(8), .DEPTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a launch, check its byte, then acknowledge it early.
  task automatic expect_launch(input string tag, input logic [7:0] exp);
    int k;
    k = 0;
    while (!u_if.tx_start && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_start"}, 32'(u_if.tx_start), 32'd1);
    check(tag, 32'(u_if.tx_data), 32'(exp));
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check({tag, "_ack"}, 32'(u_if.busy), 32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    u_if.wr_en   = 1'b1;
    u_if.wr_data = b;
    tick();
    u_if.wr_en   = 1'b0;
  endtask

  initial begin
    int  pushed;
    int  launched;
    int  cd;
    bit  ovf_seen;

    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    u_if.wr_en   = 1'b0;
    u_if.wr_data = '0;
    u_if.tx_done = 1'b0;

    // ---------------- reset values ----------------
    #2;
    check("rst_count",    32'(u_if.count),    32'd0);
    check("rst_empty",    32'(u_if.empty),    32'd1);
    check("rst_full",     32'(u_if.full),     32'd0);
    check("rst_overflow", 32'(u_if.overflow), 32'd0);
    check("rst_busy",     32'(u_if.busy),     32'd0);
    check("rst_tx_start", 32'(u_if.tx_start), 32'd0);
    check("rst_tx_data",  32'(u_if.tx_data),  32'd0);
    #10;
    rst = 1'b0;

    // ---------------- single byte ----------------
    push(8'hA5);
    check("sb_count1",  32'(u_if.count),    32'd1);
    check("sb_nostart", 32'(u_if.tx_start), 32'd0);
    tick();
    check("sb_start",   32'(u_if.tx_start), 32'd1);
    check("sb_data",    32'(u_if.tx_data),  32'hA5);
    check("sb_busy",    32'(u_if.busy),     32'd1);
    check("sb_empty",   32'(u_if.empty),    32'd1);
    tick();
    check("sb_start_1cyc", 32'(u_if.tx_start), 32'd0);
    repeat (98) tick();
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check("sb_done_busy",  32'(u_if.busy),    32'd0);
    check("sb_done_empty", 32'(u_if.empty),   32'd1);
    check("sb_done_data",  32'(u_if.tx_data), 32'hA5);

    // ---------------- fill and overflow ----------------
    for (int i = 0; i < 17; i++) push(8'(i));
    check("fill_count",   32'(u_if.count),    32'd16);
    check("fill_full",    32'(u_if.full),     32'd1);
    check("fill_empty",   32'(u_if.empty),    32'd0);
    check("fill_ovf0",    32'(u_if.overflow), 32'd0);
    check("fill_inflt",   32'(u_if.tx_data),  32'h00);
    push(8'h11);
    check("ovf_pulse",    32'(u_if.overflow), 32'd1);
    check("ovf_count",    32'(u_if.count),    32'd16);
    tick();
    check("ovf_clear",    32'(u_if.overflow), 32'd0);
    check("ovf_count2",   32'(u_if.count),    32'd16);
    // Retire the in-flight byte, then drain: 0x11 must never appear.
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    for (int i = 1; i <= 16; i++) expect_launch("drain", 8'(i));
    check("drain_empty",  32'(u_if.empty),    32'd1);

    // ---------------- ordering and wrap ----------------
    pushed   = 0;
    launched = 0;
    cd       = 0;
    ovf_seen = 1'b0;
    for (int cyc = 0; cyc < 2000 && launched < 40; cyc++) begin
      u_if.wr_en   = (pushed < 40) && !u_if.full;
      u_if.wr_data = pushed[7:0];
      u_if.tx_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) u_if.tx_done = 1'b1;
      end
      tick();
      if (u_if.wr_en) pushed++;
      if (u_if.overflow) ovf_seen = 1'b1;
      if (u_if.tx_start) begin
        check("order_data", 32'(u_if.tx_data), 32'(launched));
        launched++;
        cd = 5;
      end
    end
    u_if.wr_en   = 1'b0;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check("order_launched", 32'(launched), 32'd40);
    check("order_no_ovf",   32'(ovf_seen), 32'd0);
    check("order_idle",     32'(u_if.busy), 32'd0);
    check("order_empty",    32'(u_if.empty), 32'd1);

    // ---------------- simultaneous push and pop ----------------
    push(8'hA0);
    push(8'hB1);
    push(8'hB2);
    push(8'hB3);
    check("sim_q3",      32'(u_if.count),   32'd3);
    check("sim_busy",    32'(u_if.busy),    32'd1);
    check("sim_inflt",   32'(u_if.tx_data), 32'hA0);
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check("sim_idle",    32'(u_if.busy),    32'd0);
    check("sim_idle_q3", 32'(u_if.count),   32'd3);
    push(8'hC4);
    check("sim_count",   32'(u_if.count),    32'd3);
    check("sim_start",   32'(u_if.tx_start), 32'd1);
    check("sim_data",    32'(u_if.tx_data),  32'hB1);
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    expect_launch("sim_b2", 8'hB2);
    expect_launch("sim_b3", 8'hB3);
    expect_launch("sim_c4", 8'hC4);

    // ---------------- stray and early done ----------------
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check("stray_busy",  32'(u_if.busy),     32'd0);
    check("stray_start", 32'(u_if.tx_start), 32'd0);
    check("stray_count", 32'(u_if.count),    32'd0);
    check("stray_data",  32'(u_if.tx_data),  32'hC4);
    tick();
    check("stray_start2", 32'(u_if.tx_start), 32'd0);
    push(8'hD5);
    push(8'hD6);
    check("early_start", 32'(u_if.tx_start), 32'd1);
    check("early_data",  32'(u_if.tx_data),  32'hD5);
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check("early_idle",  32'(u_if.busy),     32'd0);
    check("early_gap",   32'(u_if.tx_start), 32'd0);
    tick();
    check("early_next",  32'(u_if.tx_start), 32'd1);
    check("early_ndata", 32'(u_if.tx_data),  32'hD6);
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
    check("mid_count", 32'(u_if.count), 32'd5);
    check("mid_busy",  32'(u_if.busy),  32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_start", 32'(u_if.tx_start), 32'd0);
    check("arst_busy",  32'(u_if.busy),     32'd0);
    check("arst_count", 32'(u_if.count),    32'd0);
    check("arst_empty", 32'(u_if.empty),    32'd1);
    check("arst_data",  32'(u_if.tx_data),  32'd0);
    #10;
    rst = 1'b0;
    u_if.tx_done = 1'b1;
    tick();
    u_if.tx_done = 1'b0;
    check("post_busy",  32'(u_if.busy),     32'd0);
    tick();
    tick();
    check("post_start", 32'(u_if.tx_start), 32'd0);
    check("post_busy2", 32'(u_if.busy),     32'd0);
    check("post_count", 32'(u_if.count),    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
